// File: rtl/trick_lock_ctrl.sv
// Trick-lock controller: checks the entered 4-digit code against a stored
// password, opens the lock on a match, counts failures into a timed alarm
// lockout, and lets the user set a new password while the lock is open.
module trick_lock_ctrl #(
  parameter int unsigned    MAX_TRIES      = 3,
  parameter int unsigned    UNLOCK_CYCLES  = 500,
  parameter int unsigned    LOCKOUT_CYCLES = 1000,
  parameter logic [15:0]    DEFAULT_PW     = 16'h1234
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       confirm_i,
  input  logic       change_req_i,
  input  logic [3:0] pw0_i,
  input  logic [3:0] pw1_i,
  input  logic [3:0] pw2_i,
  input  logic [3:0] pw3_i,
  output logic       unlocked_o,
  output logic       setting_o,
  output logic       alarm_o,
  output logic       err_pulse_o,
  output logic [1:0] err_cnt_o
);

  typedef enum logic [1:0] {
    StLocked = 2'd0,
    StOpen   = 2'd1,
    StSetpw  = 2'd2,
    StAlarm  = 2'd3
  } state_e;

  localparam logic [1:0]  MaxTries    = 2'(MAX_TRIES);
  localparam logic [15:0] UnlockLoad  = 16'(UNLOCK_CYCLES - 1);
  localparam logic [15:0] LockoutLoad = 16'(LOCKOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] stored_pw_q, stored_pw_d;
  logic [15:0] timer_q, timer_d;
  logic [1:0]  err_cnt_q, err_cnt_d;
  logic        err_pulse_q, err_pulse_d;

  logic [15:0] entry;
  logic        match;
  logic        timer_zero;

  assign entry      = {pw3_i, pw2_i, pw1_i, pw0_i};
  assign match      = (entry == stored_pw_q);
  assign timer_zero = (timer_q == 16'd0);

  // Next-state, timer, password and failure-count logic.
  always_comb begin
    state_d     = state_q;
    stored_pw_d = stored_pw_q;
    timer_d     = timer_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = 1'b0;

    case (state_q)
      StLocked: begin
        if (confirm_i) begin
          if (match) begin
            state_d   = StOpen;
            err_cnt_d = 2'd0;
            timer_d   = UnlockLoad;
          end else begin
            err_pulse_d = 1'b1;
            err_cnt_d   = err_cnt_q + 2'd1;
            // Count saturates at MaxTries while the alarm runs.
            if ((err_cnt_q + 2'd1) == MaxTries) begin
              state_d = StAlarm;
              timer_d = LockoutLoad;
            end
          end
        end
      end
      StOpen: begin
        if (change_req_i) begin
          state_d = StSetpw;
          timer_d = UnlockLoad;
        end else if (confirm_i || timer_zero) begin
          state_d = StLocked;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      StSetpw: begin
        if (confirm_i) begin
          stored_pw_d = entry;
          state_d     = StLocked;
        end else if (timer_zero) begin
          state_d = StLocked;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      StAlarm: begin
        if (timer_zero) begin
          state_d   = StLocked;
          err_cnt_d = 2'd0;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: begin
        state_d = StLocked;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StLocked;
      stored_pw_q <= DEFAULT_PW;
      timer_q     <= 16'd0;
      err_cnt_q   <= 2'd0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stored_pw_q <= stored_pw_d;
      timer_q     <= timer_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  // Status outputs are decoded straight from the state register.
  assign unlocked_o  = (state_q == StOpen);
  assign setting_o   = (state_q == StSetpw);
  assign alarm_o     = (state_q == StAlarm);
  assign err_pulse_o = err_pulse_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_trick_lock_ctrl.sv
// Directed bench for trick_lock_ctrl with short unlock/lockout timers.
module tb_trick_lock_ctrl;

  logic       clk;
  logic       reset;
  logic       confirm;
  logic       change_req;
  logic [3:0] pw0, pw1, pw2, pw3;
  logic       unlocked, setting, alarm, err_pulse;
  logic [1:0] err_cnt;

  int total = 0;
  int bad   = 0;

  trick_lock_ctrl #(
    .MAX_TRIES     (3),
    .UNLOCK_CYCLES (5),
    .LOCKOUT_CYCLES(8),
    .DEFAULT_PW    (16'h1234)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .confirm_i   (confirm),
    .change_req_i(change_req),
    .pw0_i       (pw0),
    .pw1_i       (pw1),
    .pw2_i       (pw2),
    .pw3_i       (pw3),
    .unlocked_o  (unlocked),
    .setting_o   (setting),
    .alarm_o     (alarm),
    .err_pulse_o (err_pulse),
    .err_cnt_o   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pw(input logic [15:0] code);
    {pw3, pw2, pw1, pw0} = code;
  endtask

  task automatic pulse_confirm();
    confirm = 1'b1;
    step();
    confirm = 1'b0;
  endtask

  // Outputs packed as {unlocked, setting, alarm, err_pulse, err_cnt}.
  function automatic logic [15:0] outs();
    return {10'd0, unlocked, setting, alarm, err_pulse, err_cnt};
  endfunction

  initial begin
    reset      = 1'b0;
    confirm    = 1'b0;
    change_req = 1'b0;
    set_pw(16'h0000);
    #2;
    chk("reset_outputs", outs(), 16'h00);
    #10;
    reset = 1'b1;
    step();
    chk("idle_after_reset", outs(), 16'h00);

    // Correct entry: open for exactly 5 cycles.
    set_pw(16'h1234);
    pulse_confirm();
    chk("open_first", outs(), 16'h20);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("open_hold", {15'd0, unlocked}, 16'h1);
    end
    step();
    chk("open_expired", outs(), 16'h00);

    // Three failures into alarm.
    set_pw(16'h0000);
    pulse_confirm();
    chk("fail1", outs(), 16'h05);
    step();
    chk("fail1_pulse_end", outs(), 16'h01);
    pulse_confirm();
    chk("fail2", outs(), 16'h06);
    pulse_confirm();
    chk("fail3_alarm", outs(), 16'h0F);
    set_pw(16'h1234);
    pulse_confirm();
    chk("alarm_ignores_confirm", outs(), 16'h0B);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("alarm_hold", {15'd0, alarm}, 16'h1);
    end
    step();
    chk("alarm_done", outs(), 16'h00);

    // Failures cleared by a success.
    set_pw(16'h4321);
    pulse_confirm();
    chk("ws_fail1", outs(), 16'h05);
    pulse_confirm();
    chk("ws_fail2", outs(), 16'h06);
    set_pw(16'h1234);
    pulse_confirm();
    chk("ws_open", outs(), 16'h20);
    pulse_confirm();
    chk("manual_lock", outs(), 16'h00);

    // Password change to 9876.
    pulse_confirm();
    chk("pc_open", outs(), 16'h20);
    change_req = 1'b1;
    step();
    change_req = 1'b0;
    chk("pc_setting", outs(), 16'h10);
    set_pw(16'h9876);
    pulse_confirm();
    chk("pc_stored", outs(), 16'h00);
    set_pw(16'h1234);
    pulse_confirm();
    chk("pc_old_fails", outs(), 16'h05);
    set_pw(16'h9876);
    pulse_confirm();
    chk("pc_new_opens", outs(), 16'h20);
    pulse_confirm();
    chk("pc_relock", outs(), 16'h00);

    // Asynchronous reset reverts the changed password.
    #2;
    reset = 1'b0;
    #1;
    chk("rst_locked_outputs", outs(), 16'h00);
    step();
    reset = 1'b1;
    set_pw(16'h1234);
    pulse_confirm();
    chk("rst_default_pw", outs(), 16'h20);

    // SETPW timeout keeps the password.
    change_req = 1'b1;
    step();
    change_req = 1'b0;
    chk("to_setting", outs(), 16'h10);
    set_pw(16'h5555);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("to_setting_hold", {15'd0, setting}, 16'h1);
    end
    step();
    chk("to_expired", outs(), 16'h00);
    set_pw(16'h5555);
    pulse_confirm();
    chk("to_unchanged_reject", outs(), 16'h05);
    set_pw(16'h1234);
    pulse_confirm();
    chk("to_old_pw_opens", outs(), 16'h20);

    // change_req beats confirm in OPEN.
    change_req = 1'b1;
    confirm    = 1'b1;
    step();
    change_req = 1'b0;
    confirm    = 1'b0;
    chk("simul_setpw", outs(), 16'h10);
    pulse_confirm();
    chk("simul_store", outs(), 16'h00);

    // Reset in the middle of an alarm.
    set_pw(16'hAAAA);
    pulse_confirm();
    pulse_confirm();
    pulse_confirm();
    chk("ra_alarm", outs(), 16'h0F);
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("ra_cleared", outs(), 16'h00);
    step();
    reset = 1'b1;
    set_pw(16'h1234);
    pulse_confirm();
    chk("ra_opens", outs(), 16'h20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trick_lock_ctrl.md
Name: trick_lock_ctrl

Overview:
- Downstream consumer of the 4-digit keypad entry registers (pw0..pw3) in the trick-lock design.
- On a confirm pulse, compares the entered code with a stored 16-bit password and drives the unlock output.
- Counts failed attempts and enters a timed alarm lockout after too many failures.
- Lets the user change the stored password while the lock is open.

Parameters:
- MAX_TRIES, 3: consecutive failed attempts that trigger ALARM; legal range 1..3.
- UNLOCK_CYCLES, 500: cycles the lock stays OPEN, and SETPW timeout length; legal range 1..65535.
- LOCKOUT_CYCLES, 1000: cycles spent in ALARM; legal range 1..65535.
- DEFAULT_PW, 16'h1234: password loaded at reset, packed {pw3,pw2,pw1,pw0}.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- confirm  input  1  single-cycle synchronous pulse: submit entry / store new password / manual lock
- change_req  input  1  single-cycle pulse: request password change; honoured only in OPEN
- pw0  input  4  entered digit 0 (least significant nibble)
- pw1  input  4  entered digit 1
- pw2  input  4  entered digit 2
- pw3  input  4  entered digit 3 (most significant nibble)
- unlocked  output  1  high while in OPEN
- setting  output  1  high while in SETPW
- alarm  output  1  high while in ALARM
- err_pulse  output  1  one-cycle pulse per failed attempt
- err_cnt  output  2  current consecutive-failure count

Behaviour:
- Reset (reset low, asynchronous):
  - state = LOCKED; stored_pw = DEFAULT_PW; err_cnt = 0; timer = 0.
  - unlocked, setting, alarm, err_pulse all 0.
- Registers and latency:
  - All outputs are registered and decoded from state.
  - Inputs are sampled on the rising clk edge; the response is visible the cycle after the pulse.
- Compare: match = ({pw3,pw2,pw1,pw0} == stored_pw), evaluated combinationally when confirm is sampled.
- Timer: 16-bit down counter, loaded on state entry as described below.
- LOCKED:
  - confirm & match: go to OPEN; err_cnt = 0; timer = UNLOCK_CYCLES-1.
  - confirm & !match: err_pulse = 1 for one cycle; err_cnt = err_cnt+1.
  - If the new err_cnt equals MAX_TRIES: go to ALARM; timer = LOCKOUT_CYCLES-1; err_cnt held at MAX_TRIES.
  - change_req is ignored.
- OPEN:
  - unlocked = 1, for exactly UNLOCK_CYCLES cycles if undisturbed.
  - Priority order, highest first:
    1. change_req: go to SETPW; timer = UNLOCK_CYCLES-1.
    2. confirm: go to LOCKED (manual lock).
    3. timer == 0: go to LOCKED.
    4. Otherwise timer decrements.
  - change_req and confirm in the same cycle: change_req wins.
- SETPW:
  - setting = 1; unlocked = 0.
  - confirm: stored_pw = {pw3,pw2,pw1,pw0}; go to LOCKED. The new password takes effect from the next confirm.
  - timer == 0 without confirm: go to LOCKED; stored_pw unchanged.
  - Otherwise timer decrements.
  - change_req is ignored.
- ALARM:
  - alarm = 1 for exactly LOCKOUT_CYCLES cycles.
  - confirm and change_req are ignored; no compare and no err_pulse.
  - timer == 0: go to LOCKED; err_cnt = 0.
- Boundary conditions:
  - confirm in the same cycle as timer expiry: confirm's action wins (OPEN: lock; SETPW: store).
  - UNLOCK_CYCLES = 1 or LOCKOUT_CYCLES = 1: the state lasts one cycle.
  - MAX_TRIES = 1: the first failure goes directly to ALARM.
- Reset mid-operation: any state returns immediately to LOCKED.
  - stored_pw reverts to DEFAULT_PW.
  - A password changed before reset is lost.
- Illegal state encoding: recovers to LOCKED on the next edge.

Test Plan:
- Correct entry: reset; pw = 1,2,3,4 (pw0=4, pw3=1); confirm.
  -> unlocked = 1 the next cycle, for exactly UNLOCK_CYCLES (5 in bench) cycles, then LOCKED; err_cnt = 0.
- Three wrong codes with MAX_TRIES=3, LOCKOUT_CYCLES=8:
  - Code 16'h0000, confirm three times -> err_pulse three times; err_cnt 1, 2, then 3 with alarm = 1 for 8 cycles.
  - A confirm with the correct code during ALARM is ignored.
  - After ALARM: err_cnt = 0 and LOCKED.
- Failure reset by success: wrong, wrong, correct -> err_cnt goes 1, 2, then 0; unlocked = 1; no alarm.
- Password change:
  - Unlock; change_req -> setting = 1; pw = 16'h9876; confirm -> LOCKED.
  - Code 16'h1234 then fails (err_pulse).
  - Code 16'h9876 then unlocks.
- SETPW timeout and simultaneity:
  - In SETPW, no confirm for 5 cycles -> LOCKED, stored_pw still 16'h1234.
  - In OPEN, change_req and confirm in the same cycle -> SETPW.
- Async reset mid-ALARM and after a password change:
  - Assert reset low between edges -> outputs 0 immediately.
  - After release, 16'h1234 unlocks.
